// File: rtl/cycle_loader_pkg.sv
// Shared types and constants for the cycle loader and the PWM blocks that consume CYCLE.
package cycle_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        COMMIT
    } state_e;

    // Smallest storable cycle; keeps the downstream CYCLE-2 stage from wrapping.
    localparam int MIN_CYCLE     = 2;
    localparam int DEFAULT_CYCLE = 4096;

endpackage

// File: rtl/cycle_loader_rd_valid_pipe.sv
// Valid/index delay line that lines up each issued BRAM read with its returning data.
module rd_valid_pipe #(
    parameter int LATENCY   = 2,
    parameter int IDX_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [IDX_WIDTH-1:0] idx_i,
    output logic                 valid_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    logic [LATENCY-1:0]   valid_q;
    logic [IDX_WIDTH-1:0] idx_q [LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            idx_q[0]   <= idx_i;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign idx_o   = idx_q[LATENCY-1];

endmodule

// File: rtl/cycle_loader.sv
// Streams DEPTH cycle values from BRAM into a shadow array and commits them to CYCLE in one edge.
module cycle_loader #(
    parameter int WIDTH         = 13,
    parameter int DEPTH         = 249,
    parameter int ADDR_WIDTH    = 8,
    parameter int RD_LATENCY    = 2,
    parameter int DEFAULT_CYCLE = cycle_loader_pkg::DEFAULT_CYCLE
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     UPDATE,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     EN,
    output logic [ADDR_WIDTH-1:0]    ADDR,
    input  logic [15:0]              DOUT,
    output logic [WIDTH-1:0]         CYCLE [DEPTH],
    output cycle_loader_pkg::state_e STATE
);

    import cycle_loader_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [2:0]            DRAIN_LAST = 3'(RD_LATENCY - 1);
    localparam logic [WIDTH-1:0]      DEF_VAL    = WIDTH'(DEFAULT_CYCLE);
    localparam logic [WIDTH-1:0]      MIN_VAL    = WIDTH'(MIN_CYCLE);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    en_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pending_q;
    logic [2:0]              drain_q;
    logic [WIDTH-1:0]        cycle_q  [DEPTH];
    logic [WIDTH-1:0]        shadow_q [DEPTH];

    logic                    pipe_valid;
    logic [ADDR_WIDTH-1:0]   pipe_idx;
    logic [WIDTH-1:0]        raw_d;
    logic [WIDTH-1:0]        clamped_d;
    logic                    unused_dout;

    rd_valid_pipe #(
        .LATENCY   (RD_LATENCY),
        .IDX_WIDTH (ADDR_WIDTH)
    ) u_rd_valid_pipe (
        .clk_i   (CLK),
        .rst_i   (RST),
        .valid_i (en_q),
        .idx_i   (addr_q),
        .valid_o (pipe_valid),
        .idx_o   (pipe_idx)
    );

    assign raw_d       = DOUT[WIDTH-1:0];
    assign unused_dout = ^DOUT[15:WIDTH];

    always_comb begin
        clamped_d = raw_d;
        if (raw_d < MIN_VAL) begin
            clamped_d = MIN_VAL;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= DEF_VAL;
            end
        end else if (pipe_valid && (int'(pipe_idx) < DEPTH)) begin
            shadow_q[pipe_idx] <= clamped_d;
        end
    end

    // Requests arriving outside IDLE collapse into one pending flag, served right after DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
            drain_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cycle_q[i] <= DEF_VAL;
            end
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && UPDATE) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (UPDATE || pending_q) begin
                        state_q   <= READ;
                        en_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        addr_q    <= '0;
                        pending_q <= 1'b0;
                    end
                end
                READ: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= DRAIN;
                        en_q    <= 1'b0;
                        addr_q  <= '0;
                        drain_q <= '0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= COMMIT;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        cycle_q[i] <= shadow_q[i];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign EN    = en_q;
    assign ADDR  = addr_q;
    assign CYCLE = cycle_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_cycle_loader.sv
// Directed/randomized bench for cycle_loader at read latencies 1, 2 and 4 against a BRAM model.
module tb_cycle_loader;
  import cycle_loader_pkg::*;

  localparam int W   = 13;
  localparam int D   = 249;
  localparam int AW  = 8;
  localparam int DEF = 4096;

  logic clk = 1'b0;
  logic rst;
  logic update;
  always #5 clk = ~clk;

  logic          busy [3];
  logic          done [3];
  logic          en   [3];
  logic [AW-1:0] addr [3];
  logic [15:0]   dout [3];
  state_e        state_dbg [3];
  logic [W-1:0]  cyc_l1 [D];
  logic [W-1:0]  cyc_l2 [D];
  logic [W-1:0]  cyc_l4 [D];

  logic [15:0]   mem [256];
  logic [15:0]   rd_pipe [3][4];
  logic [W-1:0]  commit_m [3][D];

  int checks = 0;
  int passes = 0;

  cycle_loader #(.RD_LATENCY(1)) u_l1 (
    .CLK(clk), .RST(rst), .UPDATE(update), .BUSY(busy[0]), .DONE(done[0]), .EN(en[0]),
    .ADDR(addr[0]), .DOUT(dout[0]), .CYCLE(cyc_l1), .STATE(state_dbg[0]));
  cycle_loader #(.RD_LATENCY(2)) u_l2 (
    .CLK(clk), .RST(rst), .UPDATE(update), .BUSY(busy[1]), .DONE(done[1]), .EN(en[1]),
    .ADDR(addr[1]), .DOUT(dout[1]), .CYCLE(cyc_l2), .STATE(state_dbg[1]));
  cycle_loader #(.RD_LATENCY(4)) u_l4 (
    .CLK(clk), .RST(rst), .UPDATE(update), .BUSY(busy[2]), .DONE(done[2]), .EN(en[2]),
    .ADDR(addr[2]), .DOUT(dout[2]), .CYCLE(cyc_l4), .STATE(state_dbg[2]));

  // BRAM model: data is read at the issuing edge, garbage is returned when not enabled.
  always @(posedge clk) begin
    for (int w = 0; w < 3; w++) begin
      rd_pipe[w][0] <= en[w] ? mem[addr[w]] : 16'($urandom);
      for (int s = 1; s < 4; s++) rd_pipe[w][s] <= rd_pipe[w][s-1];
    end
  end
  assign dout[0] = rd_pipe[0][0];
  assign dout[1] = rd_pipe[1][1];
  assign dout[2] = rd_pipe[2][3];

  function automatic int lat_of(int w);
    return (w == 0) ? 1 : ((w == 1) ? 2 : 4);
  endfunction

  function automatic logic [W-1:0] cyc_of(int w, int i);
    case (w)
      0:       return cyc_l1[i];
      1:       return cyc_l2[i];
      default: return cyc_l4[i];
    endcase
  endfunction

  function automatic logic [W-1:0] ref_clamp(logic [15:0] v);
    int low;
    low = int'(v) % 8192;
    if (low < 2) return W'(2);
    return W'(low);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
  endtask

  task automatic check_all_arrays(input string tag);
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < D; i++) check(tag, cyc_of(w, i), commit_m[w][i]);
  endtask

  // One UPDATE pulse observed on all three latencies; cycle 0 is the cycle UPDATE is sampled.
  task automatic run_full_load(input string tag);
    logic [W-1:0] exp_new [D];
    for (int i = 0; i < D; i++) exp_new[i] = ref_clamp(mem[i]);
    update = 1'b1;
    tick();
    update = 1'b0;
    for (int n = 1; n <= 260; n++) begin
      for (int w = 0; w < 3; w++) begin
        int dc;
        dc = D + lat_of(w) + 2;
        check({tag, "_en"}, en[w], n <= D);
        if (n <= D) check({tag, "_addr"}, addr[w], n - 1);
        check({tag, "_done"}, done[w], n == dc);
        check({tag, "_busy"}, busy[w], n < dc);
        check({tag, "_first"}, cyc_of(w, 0), (n < dc) ? commit_m[w][0] : exp_new[0]);
        check({tag, "_last"}, cyc_of(w, D - 1), (n < dc) ? commit_m[w][D-1] : exp_new[D-1]);
      end
      tick();
    end
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < D; i++) commit_m[w][i] = exp_new[i];
    check_all_arrays({tag, "_arr"});
  endtask

  initial begin
    int done_cnt;
    rst    = 1'b1;
    update = 1'b0;
    fill_random();
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < D; i++) commit_m[w][i] = W'(DEF);

    // Reset held three cycles, then idle with DOUT toggling underneath.
    repeat (3) tick();
    rst = 1'b0;
    check_all_arrays("reset_arr");
    for (int n = 0; n < 8; n++) begin
      for (int w = 0; w < 3; w++) begin
        check("idle_busy", busy[w], 1'b0);
        check("idle_done", done[w], 1'b0);
        check("idle_en", en[w], 1'b0);
        check("idle_addr", addr[w], 0);
        check("idle_cyc", cyc_of(w, n), DEF);
      end
      tick();
    end

    // Basic ramp load.
    for (int i = 0; i < 256; i++) mem[i] = 16'(1000 + i);
    run_full_load("basic");
    check("basic_c0", cyc_l2[0], 1000);
    check("basic_c248", cyc_l2[248], 1248);

    // Clamp and upper-bit masking.
    fill_random();
    mem[0] = 16'd0;
    mem[1] = 16'd1;
    mem[2] = 16'd2;
    mem[3] = 16'hE123;
    mem[4] = 16'd8191;
    run_full_load("clamp");
    check("clamp0", cyc_l2[0], 2);
    check("clamp1", cyc_l2[1], 2);
    check("clamp2", cyc_l2[2], 2);
    check("clamp3", cyc_l2[3], 32'h0123);
    check("clamp4", cyc_l2[4], 8191);

    fill_random();
    run_full_load("rand_a");
    fill_random();
    run_full_load("rand_b");

    // Pending merge: three requests yield exactly two loads, the second reading the rewritten BRAM.
    for (int i = 0; i < 256; i++) mem[i] = 16'(2000 + i);
    done_cnt = 0;
    update = 1'b1;
    tick();
    for (int n = 1; n <= 520; n++) begin
      update = (n == 10) || (n == 100);
      if (n == 50) for (int i = 0; i < 256; i++) mem[i] = 16'(3000 + i);
      if (done[1]) done_cnt++;
      check("pend_done", done[1], (n == 253) || (n == 506));
      if (n >= 254 && n <= 254 + D - 1) begin
        check("pend_en2", en[1], 1'b1);
        check("pend_addr2", addr[1], n - 254);
      end
      if (n == 253) check("pend_gap_en", en[1], 1'b0);
      if (n >= 507) begin
        check("pend_quiet_en", en[1], 1'b0);
        check("pend_quiet_busy", busy[1], 1'b0);
      end
      tick();
    end
    update = 1'b0;
    check("pend_loads", done_cnt, 2);
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < D; i++) commit_m[w][i] = ref_clamp(16'(3000 + i));
    check_all_arrays("pend_arr");

    // Abort a load with reset at cycle 120.
    fill_random();
    update = 1'b1;
    tick();
    update = 1'b0;
    for (int n = 1; n < 120; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < D; i++) commit_m[w][i] = W'(DEF);
    check_all_arrays("abort_arr");
    for (int n = 0; n < 300; n++) begin
      for (int w = 0; w < 3; w++) begin
        check("abort_done", done[w], 1'b0);
        check("abort_busy", busy[w], 1'b0);
        check("abort_en", en[w], 1'b0);
      end
      tick();
    end
    fill_random();
    run_full_load("reload");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
